// File: rtl/fifo_serial_tx.sv
// Read-side consumer for the 10-bit memory FIFO. It pops one word at a time and
// sends it as a start/data(LSB first)/stop frame on a single idle-high line.
module fifo_serial_tx #(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Enable,
    input  logic              Empty,
    input  logic [DATA_W-1:0] FIFO_Dout,
    output logic              RD_EN,
    output logic              TX,
    output logic              Busy,
    output logic [CNT_W-1:0]  Frame_Cnt
);

    localparam int unsigned BIT_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    logic [DATA_W-1:0]     shift_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]      bit_idx;

    // The pop strobe is decoded from IDLE so it can only be a single-cycle pulse.
    assign RD_EN = (state == IDLE) && Enable && !Empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            TX        <= 1'b1;
            Busy      <= 1'b0;
            Frame_Cnt <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    TX      <= 1'b1;
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (RD_EN) begin
                        state <= POP;
                        Busy  <= 1'b1;
                    end else begin
                        Busy  <= 1'b0;
                    end
                end
                POP: begin
                    shift_reg <= FIFO_Dout;
                    TX        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        TX      <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == IDX_LAST) begin
                            TX    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next data bit is the one about to shift into position 0.
                            TX      <= shift_reg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    TX <= 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        Frame_Cnt <= Frame_Cnt + CNT_W'(1);
                        Busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
